serial_adder_ctrl: RTL



---
 rtl/serial_adder_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder cell, LSB first, one bit pair per slot.
// Each slot lasts SETTLE clocks so the gate-level cell can settle.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic carryin,
  output logic sum,
  output logic carryout
);

  logic axb;
  logic ab;
  logic cx;

  assign axb      = a ^ b;
  assign ab       = a & b;
  assign cx       = carryin & axb;
  assign sum      = axb ^ carryin;
  assign carryout = ab | cx;

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             carry_q;
  logic [BW-1:0]    bit_cnt;
  logic [SW-1:0]    set_cnt;
  logic             fa_sum;
  logic             fa_carryout;
  logic [WIDTH-1:0] s_next;

  full_adder u_fa (
    .a        (a_sh[0]),
    .b        (b_sh[0]),
    .carryin  (carry_q),
    .sum      (fa_sum),
    .carryout (fa_carryout)
  );

  assign s_next = {fa_sum, s_sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      carry_q <= 1'b0;
      bit_cnt <= '0;
      set_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= cin;
            bit_cnt <= '0;
            set_cnt <= '0;
            busy    <= 1'b1;
            state   <= ADD;
          end
        end
        ADD: begin
          if (set_cnt == SET_LAST) begin
            set_cnt <= '0;
            s_sh    <= s_next;
            carry_q <= fa_carryout;
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            bit_cnt <= bit_cnt + 1'b1;
            // last slot: publish result on the same edge
            if (bit_cnt == BIT_LAST) begin
              sum   <= s_next;
              cout  <= fa_carryout;
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            set_cnt <= set_cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
